serial_comparator_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit operands by running an external 2-bit magnitude comparator slice over successive bit pairs, MSB pair first.
- Operands are captured on a start pulse. Each cycle, one 2-bit slice is driven to the comparator and its eq/gt/lt result is sampled.
- Returns registered AequalsB/AgreaterB/AlessB with a one-cycle done pulse.
- Lets one 2-bit comparator instance serve arbitrary operand widths.

---
 rtl/serial_comparator_ctrl_if.sv | 30 +++
 rtl/serial_comparator_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_comparator_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_ctrl_if.sv
// Handshake and comparator-slice bundle for the serial comparator sequencer.
// slave = sequencer side; master = requester plus external 2-bit comparator.
interface serial_comparator_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       sliceA;
    logic [1:0]       sliceB;
    logic             slice_eq;
    logic             slice_gt;
    logic             slice_lt;
    logic             busy;
    logic             done;
    logic             AequalsB;
    logic             AgreaterB;
    logic             AlessB;
    logic             err;

    modport slave (
        input  start, A, B, slice_eq, slice_gt, slice_lt,
        output sliceA, sliceB, busy, done, AequalsB, AgreaterB, AlessB, err
    );

    modport master (
        output start, A, B, slice_eq, slice_gt, slice_lt,
        input  sliceA, sliceB, busy, done, AequalsB, AgreaterB, AlessB, err
    );
endinterface

// File: rtl/serial_comparator_ctrl.sv
// Walks two WIDTH-bit operands MSB pair first through one external 2-bit
// magnitude comparator and returns a registered eq/gt/lt result with a done pulse.
module serial_comparator_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_comparator_ctrl_if.slave   bus
);
    localparam int NSLICE = WIDTH / 2;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    typedef struct packed {
        logic gt;
        logic lt;
    } outcome_t;

    state_t                  state, nextState;
    logic [NSLICE-1:0][1:0]  opA, opB;
    logic [IW-1:0]           idx;
    logic                    decided;
    outcome_t                rec, nextRec;
    logic                    flagsOk, sliceDiff, lastSlice;
    logic                    errR, eqR, gtR, ltR;

    // Comparator must report exactly one relation per slice.
    always_comb begin
        case ({bus.slice_eq, bus.slice_gt, bus.slice_lt})
            3'b100, 3'b010, 3'b001: flagsOk = 1'b1;
            default:                flagsOk = 1'b0;
        endcase
    end

    assign sliceDiff = flagsOk & ~bus.slice_eq;
    assign lastSlice = (idx == '0);

    // Only the first unequal slice decides; later slices cannot override it.
    always_comb begin
        nextRec = rec;
        if (!decided) begin
            nextRec.gt = sliceDiff & bus.slice_gt;
            nextRec.lt = sliceDiff & bus.slice_lt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = COMPARE;
            COMPARE: begin
                if (!flagsOk)
                    nextState = DONE;
                else if ((EARLY_EXIT != 0) && !decided && sliceDiff)
                    nextState = DONE;
                else if (lastSlice)
                    nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.sliceA = 2'b00;
        bus.sliceB = 2'b00;
        case (state)
            COMPARE: begin
                bus.busy   = 1'b1;
                bus.sliceA = opA[idx];
                bus.sliceB = opB[idx];
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opA     <= '0;
            opB     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            rec     <= '0;
            errR    <= 1'b0;
            eqR     <= 1'b0;
            gtR     <= 1'b0;
            ltR     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opA     <= bus.A;
                        opB     <= bus.B;
                        idx     <= IW'(NSLICE - 1);
                        decided <= 1'b0;
                        rec     <= '0;
                        errR    <= 1'b0;
                        eqR     <= 1'b0;
                        gtR     <= 1'b0;
                        ltR     <= 1'b0;
                    end
                end
                COMPARE: begin
                    // A bad slice aborts with results left at their cleared zeros.
                    if (!flagsOk) begin
                        errR <= 1'b1;
                    end else begin
                        rec     <= nextRec;
                        decided <= decided | sliceDiff;
                        if (nextState == DONE) begin
                            gtR <= nextRec.gt;
                            ltR <= nextRec.lt;
                            eqR <= ~nextRec.gt & ~nextRec.lt;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.err       = errR;
    assign bus.AequalsB  = eqR;
    assign bus.AgreaterB = gtR;
    assign bus.AlessB    = ltR;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Self-checking bench: one early-exit and one constant-latency sequencer,
// each fed by a behavioural 2-bit comparator with optional flag corruption.
module tb_serial_comparator_ctrl;
    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] forceBad;

    serial_comparator_ctrl_if #(.WIDTH(WIDTH)) bus1 ();
    serial_comparator_ctrl_if #(.WIDTH(WIDTH)) bus0 ();

    serial_comparator_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    serial_comparator_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    assign bus1.slice_eq = (bus1.sliceA == bus1.sliceB) | forceBad[1];
    assign bus1.slice_gt = (bus1.sliceA >  bus1.sliceB) | forceBad[1];
    assign bus1.slice_lt = (bus1.sliceA <  bus1.sliceB);
    assign bus0.slice_eq = (bus0.sliceA == bus0.sliceB) | forceBad[0];
    assign bus0.slice_gt = (bus0.sliceA >  bus0.sliceB) | forceBad[0];
    assign bus0.slice_lt = (bus0.sliceA <  bus0.sliceB);

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       eqR;
        logic       gtR;
        logic       ltR;
        logic       err;
        logic [1:0] sa;
        logic [1:0] sb;
    } obs_t;

    function automatic obs_t obs(input int ee);
        obs_t o;
        if (ee != 0) o = '{bus1.busy, bus1.done, bus1.AequalsB, bus1.AgreaterB,
                           bus1.AlessB, bus1.err, bus1.sliceA, bus1.sliceB};
        else         o = '{bus0.busy, bus0.done, bus0.AequalsB, bus0.AgreaterB,
                           bus0.AlessB, bus0.err, bus0.sliceA, bus0.sliceB};
        return o;
    endfunction

    task automatic drive(input int ee, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (ee != 0) begin bus1.start = s; bus1.A = a; bus1.B = b; end
        else         begin bus0.start = s; bus0.A = a; bus0.B = b; end
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Caller is mid-cycle in an IDLE cycle; returns at the negedge of the
    // IDLE cycle following done, so a back-to-back start can be issued next.
    task automatic runCmp(input int ee, input logic [7:0] a, input logic [7:0] b,
                          input int badCycle, input bit poke);
        int diffIdx, kNat, k, sIdx;
        bit isErr;
        logic eqE, gtE, ltE;
        logic [7:0] expA, expB;
        obs_t o;

        diffIdx = -1;
        for (int i = NSLICE - 1; i >= 0; i--)
            if (diffIdx < 0 && ((a >> (2 * i)) & 8'h3) != ((b >> (2 * i)) & 8'h3))
                diffIdx = i;
        kNat  = (ee != 0 && diffIdx >= 0) ? NSLICE - diffIdx : NSLICE;
        isErr = (badCycle > 0) && (badCycle <= kNat);
        k     = isErr ? badCycle : kNat;
        eqE   = !isErr && (a == b);
        gtE   = !isErr && (a >  b);
        ltE   = !isErr && (a <  b);

        drive(ee, 1'b1, a, b);
        @(posedge clk); #1;
        for (int c = 1; c <= k + 1; c++) begin
            forceBad[ee] = (c == badCycle);
            drive(ee, poke && c >= 2 && c <= 4, ~a, b ^ 8'h5A);
            @(negedge clk);
            o = obs(ee);
            check("busy", o.busy, 1'b1);
            check("done", o.done, (c == k + 1));
            if (c <= k) begin
                sIdx = NSLICE - c;
                expA = (a >> (2 * sIdx)) & 8'h3;
                expB = (b >> (2 * sIdx)) & 8'h3;
                check("sliceA", o.sa, expA);
                check("sliceB", o.sb, expB);
            end else begin
                check("slicesIdle", {o.sa, o.sb}, 4'h0);
            end
            if (c == 1)
                check("resultsCleared", {o.eqR, o.gtR, o.ltR, o.err}, 4'h0);
            if (c == k + 1)
                check("result", {o.eqR, o.gtR, o.ltR, o.err}, {eqE, gtE, ltE, isErr});
            @(posedge clk); #1;
        end
        forceBad[ee] = 1'b0;
        drive(ee, 1'b0, a, b);
        @(negedge clk);
        o = obs(ee);
        check("idleAfterDone", {o.busy, o.done}, 2'b00);
        check("resultsHeld", {o.eqR, o.gtR, o.ltR, o.err}, {eqE, gtE, ltE, isErr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        logic [7:0] ra, rb;
        int ee, bad;
        bit pk;

        forceBad = 2'b00;
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset1", obs(1), 10'h0);
        check("reset0", obs(0), 10'h0);

        runCmp(1, 8'hB4, 8'hB4, 0, 0);
        runCmp(1, 8'hC0, 8'h3F, 0, 0);
        runCmp(0, 8'hC0, 8'h3F, 0, 0);
        runCmp(1, 8'h12, 8'h13, 0, 0);
        runCmp(1, 8'hFF, 8'h00, 0, 0);
        runCmp(1, 8'h5A, 8'h59, 0, 1);
        runCmp(0, 8'h5A, 8'h59, 0, 1);

        // Reset mid-operation abandons it without a done pulse.
        drive(1, 1'b1, 8'h55, 8'h54);
        @(posedge clk); #1 drive(1, 1'b0, 8'h55, 8'h54);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midReset", obs(1), 10'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            o = obs(1);
            check("noDoneAfterReset", {o.busy, o.done}, 2'b00);
        end
        runCmp(1, 8'h55, 8'h54, 0, 0);

        runCmp(1, 8'hB4, 8'hB4, 2, 0);
        runCmp(1, 8'hB4, 8'hB4, 0, 0);
        runCmp(0, 8'h80, 8'h40, 3, 0);
        runCmp(0, 8'h80, 8'h40, 0, 0);

        for (int n = 0; n < 80; n++) begin
            ee = $urandom_range(0, 1);
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = {ra[7:4], 4'($urandom)};
                default: rb = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 5) == 0) ? $urandom_range(1, NSLICE) : 0;
            pk  = 1'($urandom_range(0, 1));
            runCmp(ee, ra, rb, bad, pk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
